// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity codes and default bit timing.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int UART_BIT_CYC_9600 = 5208;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter.
// The head entry is visible on rd_data in the same cycle as rd_en.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic        do_wr;
    logic        do_rd;

    // Extra wrap bit tells full from empty when the indices match.
    assign full    = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign rd_data = mem_q[rd_q[AW-1:0]];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_wr) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_rd) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: FIFO-buffered bytes sent LSB-first with start bit,
// optional parity and one or two stop bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int BIT_CYC    = UART_BIT_CYC_9600,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic       tx_uart,
    output logic       busy
);

    localparam int CYC_W = $clog2(BIT_CYC);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_e      state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       bit_end;
    logic [7:0] head;

    assign push    = tx_vld && !full;
    assign tx_rdy  = !full;
    assign busy    = (state_q != ST_IDLE) || !empty;
    assign bit_end = (cyc_q == CYC_LAST);
    assign tx_uart = tx_q;

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push),
        .wr_data(tx_data),
        .rd_en  (pop),
        .rd_data(head),
        .full   (full),
        .empty  (empty)
    );

    // Line value follows the current state; the output register adds
    // one clock, so the start bit appears one edge after entering START.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        if (state_q != ST_IDLE) begin
            cyc_d = bit_end ? '0 : cyc_q + 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                    cyc_d   = '0;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                tx_d = (PARITY == PAR_ODD) ? ~par_q : par_q;
                if (bit_end) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            shift_d = head;
            par_d   = ^head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four small-BIT_CYC variants
// plus one default-timing instance.
module tb_uart_tx_frame;

    localparam int BC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       vld  [5];
    logic       rdy  [5];
    logic       uart [5];
    logic       busy [5];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int sel = 0;
    int nframes = 0;
    int last_hs = 0;
    logic [7:0] sb[$];
    int starts[$];

    int par_cfg[4]  = '{0, 2, 1, 0};
    int stop_cfg[4] = '{1, 1, 1, 2};

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame #(.BIT_CYC(BC), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_vld(vld[0]),
        .tx_rdy(rdy[0]), .tx_uart(uart[0]), .busy(busy[0]));
    uart_tx_frame #(.BIT_CYC(BC), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_vld(vld[1]),
        .tx_rdy(rdy[1]), .tx_uart(uart[1]), .busy(busy[1]));
    uart_tx_frame #(.BIT_CYC(BC), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_vld(vld[2]),
        .tx_rdy(rdy[2]), .tx_uart(uart[2]), .busy(busy[2]));
    uart_tx_frame #(.BIT_CYC(BC), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_vld(vld[3]),
        .tx_rdy(rdy[3]), .tx_uart(uart[3]), .busy(busy[3]));
    uart_tx_frame u4 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_vld(vld[4]),
        .tx_rdy(rdy[4]), .tx_uart(uart[4]), .busy(busy[4]));

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected per-clock line samples for one frame of byte b on variant k.
    function automatic void build(input logic [7:0] b, input int k,
                                  output logic [63:0] v, output int n);
        logic [11:0] bits;
        int nb;
        bits = '0;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = b[i]; nb++;
        end
        if (par_cfg[k] == 1) begin
            bits[nb] = ~^b; nb++;
        end
        if (par_cfg[k] == 2) begin
            bits[nb] = ^b; nb++;
        end
        for (int s = 0; s < stop_cfg[k]; s++) begin
            bits[nb] = 1'b1; nb++;
        end
        v = '0;
        n = 0;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < BC; c++) begin
                v[n] = bits[i]; n++;
            end
        end
    endfunction

    initial begin : mon
        logic prev, cur, abort;
        logic [63:0] got, exp_v;
        logic [7:0] b;
        int n;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            cur = uart[sel];
            if (!rst && prev && !cur) begin
                starts.push_back(cyc);
                nframes++;
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) b = sb.pop_front();
                else b = 8'h00;
                build(b, sel, exp_v, n);
                got = '0;
                got[0] = cur;
                abort = 1'b0;
                for (int i = 1; i < n; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                        break;
                    end
                    got[i] = uart[sel];
                end
                if (!abort) chk("frame", got, exp_v);
                cur = uart[sel];
            end
            prev = cur;
        end
    end

    task automatic push(input int k, input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        data = b;
        vld[k] = 1'b1;
        while (!rdy[k] && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("push_rdy", 64'(rdy[k]), 64'd1);
        if (rdy[k]) begin
            if (k < 4) sb.push_back(b);
            last_hs = cyc + 1;
        end
        @(posedge clk);
    endtask

    task automatic rls(input int k);
        @(negedge clk);
        vld[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int limit);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while ((busy[k] || sb.size() != 0) && w < limit);
        chk("idle", 64'(busy[k]), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int hs, hs1, w, n0, lows;
        longint t0, t1;
        rst = 1'b1;
        data = 8'h00;
        for (int k = 0; k < 5; k++) vld[k] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("rst_uart", 64'(uart[k]), 64'd1);
            chk("rst_busy", 64'(busy[k]), 64'd0);
            chk("rst_rdy", 64'(rdy[k]), 64'd1);
        end
        rst = 1'b0;

        // single byte, no parity
        sel = 0;
        push(0, 8'h31);
        hs = last_hs;
        rls(0);
        chk("busy_hi", 64'(busy[0]), 64'd1);
        w = 0;
        while (busy[0] && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("busy_len", 64'(cyc - hs), 64'd41);
        chk("start_lat", 64'(starts[starts.size()-1] - hs), 64'd2);
        repeat (4) @(negedge clk);

        // even then odd parity
        sel = 1;
        push(1, 8'h31);
        rls(1);
        wait_idle(1, 200);
        sel = 2;
        push(2, 8'h31);
        rls(2);
        wait_idle(2, 200);

        // two stop bits, back to back
        sel = 3;
        push(3, 8'h00);
        push(3, 8'hFF);
        rls(3);
        wait_idle(3, 300);
        chk("b2b_gap", 64'(starts[starts.size()-1] - starts[starts.size()-2]),
            64'd44);

        // fill the FIFO with tx_vld held high
        sel = 0;
        n0 = nframes;
        push(0, 8'h01);
        hs1 = last_hs;
        for (int i = 2; i <= 5; i++) push(0, 8'(i));
        chk("burst", 64'(last_hs - hs1), 64'd4);
        @(negedge clk);
        chk("rdy_full", 64'(rdy[0]), 64'd0);
        push(0, 8'h06);
        rls(0);
        wait_idle(0, 600);
        chk("nframes6", 64'(nframes - n0), 64'd6);

        // reset in the middle of a frame
        n0 = nframes;
        push(0, 8'hA5);
        push(0, 8'h11);
        push(0, 8'h22);
        rls(0);
        w = 0;
        while (nframes == n0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("rst_frame_seen", 64'(nframes - n0), 64'd1);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_uart", 64'(uart[0]), 64'd1);
        chk("mid_rst_busy", 64'(busy[0]), 64'd0);
        chk("mid_rst_rdy", 64'(rdy[0]), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        n0 = nframes;
        lows = 0;
        repeat (150) begin
            @(negedge clk);
            if (!uart[0]) lows++;
        end
        chk("quiet_after_rst", 64'(lows), 64'd0);
        chk("frames_after_rst", 64'(nframes - n0), 64'd0);

        // default 50 MHz / 9600 baud timing
        push(4, 8'h31);
        rls(4);
        w = 0;
        while (uart[4] && w < 10) begin
            @(negedge clk);
            w++;
        end
        t0 = $time;
        w = 0;
        while (!uart[4] && w < 6000) begin
            @(negedge clk);
            w++;
        end
        t1 = $time;
        chk("bit_time", 64'(t1 - t0), 64'd104160);
        chk("busy_dflt", 64'(busy[4]), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
